// File: rtl/audio_mode_sequencer_if.sv
// Handshake and strobe bundle between user/config logic and the audio mode sequencer.
// The master side issues mode requests; the slave side (the sequencer) returns
// status, sample strobes, the generator control word and the mute gate.
interface audio_mode_sequencer_if;
    logic       mode_req;
    logic [1:0] mode_sel;
    logic       mode_ack;
    logic       busy;
    logic       sample_end;
    logic       sample_req;
    logic [3:0] control;
    logic       mute;

    modport master (
        output mode_req, mode_sel,
        input  mode_ack, busy, sample_end, sample_req, control, mute
    );

    modport slave (
        input  mode_req, mode_sel,
        output mode_ack, busy, sample_end, sample_req, control, mute
    );
endinterface

// File: rtl/audio_mode_sequencer.sv
// Audio mode sequencer: divides clk into sample periods, emits the ADC/DAC
// sample strobes and walks the generator through click-free mode changes
// (mute, switch on a sample boundary, mute, release).
module audio_mode_sequencer #(
    parameter int DIV          = 16,
    parameter int MUTE_SAMPLES = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    audio_mode_sequencer_if.slave        bus
);

    localparam int                 CNT_W    = (DIV <= 2) ? 1 : $clog2(DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_END  = CNT_W'(DIV - 2);
    localparam logic [7:0]         MS_LAST  = 8'(MUTE_SAMPLES - 1);
    localparam bit                 NO_MUTE  = (MUTE_SAMPLES == 0);

    typedef enum logic [2:0] {
        S_RUN,
        S_MUTE_OUT,
        S_SWITCH,
        S_MUTE_IN,
        S_DONE
    } state_t;

    logic [CNT_W-1:0] cnt;
    logic             sample_end_r;
    logic             sample_req_r;

    state_t           state;
    logic [1:0]       target;
    logic [7:0]       mcnt;
    logic [3:0]       control_r;
    logic             busy_r;
    logic             mute_r;
    logic             ack_r;

    // Map a requested mode code onto the generator's SINE/FEEDBACK bits;
    // reserved code 3 is treated as silence so 2'b11 can never be driven.
    function automatic logic [1:0] encode(input logic [1:0] sel);
        case (sel)
            2'd1:    encode = 2'b01;
            2'd2:    encode = 2'b10;
            default: encode = 2'b00;
        endcase
    endfunction

    // Free-running sample divider; strobes are registered so they trail the count by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            sample_end_r <= 1'b0;
            sample_req_r <= 1'b0;
        end else begin
            cnt          <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            sample_end_r <= (cnt == CNT_END);
            sample_req_r <= (cnt == CNT_LAST);
        end
    end

    // Mode-change sequencer with registered status, mute and control outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_RUN;
            target    <= 2'b00;
            mcnt      <= 8'd0;
            control_r <= 4'b0000;
            busy_r    <= 1'b0;
            mute_r    <= 1'b0;
            ack_r     <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            case (state)
                S_RUN: begin
                    if (bus.mode_req && !busy_r) begin
                        if (encode(bus.mode_sel) == control_r[1:0]) begin
                            ack_r <= 1'b1;
                        end else begin
                            target <= encode(bus.mode_sel);
                            mcnt   <= 8'd0;
                            busy_r <= 1'b1;
                            mute_r <= !NO_MUTE;
                            state  <= NO_MUTE ? S_SWITCH : S_MUTE_OUT;
                        end
                    end
                end
                S_MUTE_OUT: begin
                    if (sample_req_r) begin
                        if (mcnt == MS_LAST) begin
                            mcnt  <= 8'd0;
                            state <= S_SWITCH;
                        end else begin
                            mcnt <= mcnt + 8'd1;
                        end
                    end
                end
                S_SWITCH: begin
                    control_r <= {2'b00, target};
                    if (NO_MUTE) begin
                        ack_r <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_MUTE_IN;
                    end
                end
                S_MUTE_IN: begin
                    if (sample_req_r) begin
                        if (mcnt == MS_LAST) begin
                            mcnt  <= 8'd0;
                            ack_r <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            mcnt <= mcnt + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                    mute_r <= 1'b0;
                    state  <= S_RUN;
                end
                default: begin
                    busy_r <= 1'b0;
                    mute_r <= 1'b0;
                    state  <= S_RUN;
                end
            endcase
        end
    end

    assign bus.sample_end = sample_end_r;
    assign bus.sample_req = sample_req_r;
    assign bus.control    = control_r;
    assign bus.busy       = busy_r;
    assign bus.mute       = mute_r;
    assign bus.mode_ack   = ack_r;

endmodule

// File: doc/audio_mode_sequencer.md
Name: audio_mode_sequencer

Overview:
- Controller for the sample-based audio generator datapath (sine / feedback / silence source).
- Generates the periodic sample_end / sample_req strobes from a clock divider and drives the generator's 4-bit control word.
- Mode changes are sequenced click-free: mute, switch control on a sample boundary, mute, then release.
- Sits between user/config logic and the generator; mute gates the generator output downstream.

Parameters:
DIV, 16, clk cycles per sample period; legal range 4..65535.
MUTE_SAMPLES, 4, sample periods muted before and after a switch; 0 disables muting; legal range 0..255.

Ports:
clk  in  1  system clock; single clock domain.
reset_n  in  1  asynchronous active-low reset.
mode_req  in  1  single-cycle pulse requesting a mode change.
mode_sel  in  2  requested mode, sampled with mode_req: 0 = silence, 1 = sine, 2 = feedback, 3 = silence (reserved).
mode_ack  out  1  one-cycle pulse when the requested mode is fully applied.
busy  out  1  high while a mode change is in progress.
sample_end  out  1  one-cycle strobe: input sample valid (ADC side).
sample_req  out  1  one-cycle strobe: output sample requested (DAC side).
control  out  4  generator control; bit0 = SINE, bit1 = FEEDBACK, bits3:2 always 0.
mute  out  1  high = downstream forces audio to zero.

Behaviour:
- Reset (async assert, sync release):
  - control=4'b0000, mute=0, busy=0, mode_ack=0, sample_end=0, sample_req=0.
  - Divider cnt=0, FSM=RUN, current mode=silence.
- Divider:
  - cnt counts 0..DIV-1, then wraps; it runs in every state.
  - sample_end=1 exactly when cnt==DIV-2.
  - sample_req=1 exactly when cnt==DIV-1.
  - All strobes are registered. First sample_req occurs DIV cycles after reset release.
- Mode encoding to control: silence -> 0000; sine -> 0001; feedback -> 0010. Never drive 0011.
- Acceptance:
  - A request is accepted on a cycle with mode_req=1 and busy=0; mode_sel is latched that cycle.
  - mode_req while busy=1 is ignored (dropped; no queueing).
  - If the accepted mode equals the current mode: mode_ack pulses the next cycle, with no mute and busy staying 0.
- FSM states:
  - RUN: idle. On a different-mode accept: busy=1 and mute=1 from the next cycle. Go to MUTE_OUT, or to SWITCH if MUTE_SAMPLES=0.
  - MUTE_OUT: 8-bit counter counts sample_req pulses, starting with the first sample_req after acceptance. On the cycle of the MUTE_SAMPLES-th pulse, go to SWITCH.
  - SWITCH: lasts exactly one cycle; control is loaded with the new encoding (visible the next cycle). Go to MUTE_IN, or to DONE if MUTE_SAMPLES=0.
  - MUTE_IN: counts MUTE_SAMPLES further sample_req pulses. On the last one, go to DONE.
  - DONE: one cycle; mode_ack=1. Next cycle mute=0, busy=0, state RUN.
- Mute and busy:
  - When MUTE_SAMPLES=0, mute never rises.
  - busy is high from the cycle after accept through the DONE cycle inclusive.
- Simultaneous events:
  - sample_req on the same cycle as acceptance is not counted.
  - sample_req on the SWITCH cycle is not counted toward MUTE_IN.
- Reset mid-sequence: immediately returns all outputs to reset values (control=0, mute=0); the in-flight request is lost and not acked.
- control changes only in the cycle after SWITCH; it never changes in RUN.

Test Plan:
- Divider (DIV=8): after reset release, sample_end at cycles 7, 15, 23 and sample_req at cycles 8, 16, 24; sample_req period is exactly 8 cycles over 100 periods.
- Full switch (DIV=8, MUTE_SAMPLES=2): pulse mode_req with mode_sel=1 at cycle 3 -> mute=1 from cycle 4; control=0001 after the 2nd sample_req; mute stays high for 2 more sample_req; then mode_ack one cycle, then mute=0 and busy=0.
- Same-mode request: with current mode sine, pulse mode_req with mode_sel=1 -> mode_ack the next cycle; mute, busy and control unchanged.
- Busy drop: during a switch to feedback, pulse mode_req with mode_sel=1 -> ignored; final control=0010 and exactly one mode_ack.
- MUTE_SAMPLES=0 and reserved code: mode_sel=3 from sine -> control=0000 within 3 cycles; mute never rises; mode_ack pulses once.
- Reset mid-MUTE_IN: assert reset_n=0 asynchronously -> control=0000, mute=0, busy=0 without waiting for clk; no mode_ack after release.
